// File: rtl/arbiter_n_to_1_request_cache_pkg.sv
// Shared types and constants for the N-to-1 cache request arbiter.
// Also holds the modular wrap helper used by the round-robin logic.
package arbiter_n_to_1_request_cache_pkg;

    localparam int ARBITER_MAX_REQUESTORS = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] meta;
    } MemoryPacketPayload;

    typedef struct packed {
        logic               valid;
        MemoryPacketPayload payload;
    } MemoryPacketRequest;

    typedef enum logic [1:0] {
        SETUP,
        RUN,
        STALL
    } arbiter_request_state_t;

    // Operands are always < 2*n, so a single conditional subtract is a full mod.
    function automatic int unsigned rr_wrap(input int unsigned i, input int unsigned n);
        return (i >= n) ? i - n : i;
    endfunction

endpackage

// File: rtl/arbiter_n_to_1_request_cache_if.sv
// Request-side bus of the N-to-1 cache request arbiter.
// slave = arbiter side, master = requesters / cache / response-path side.
interface arbiter_n_to_1_request_cache_if
    import arbiter_n_to_1_request_cache_pkg::*;
#(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int CREDIT_W             = 5
) ();

    MemoryPacketRequest [NUM_MEMORY_REQUESTOR-1:0] request_in;
    logic [NUM_MEMORY_REQUESTOR-1:0]               request_ready;
    logic                                          fifo_setup_signal;
    logic                                          downstream_prog_full;
    logic                                          response_retire;
    MemoryPacketRequest                            request_out;
    logic [CREDIT_W-1:0]                           credits_available;
    logic                                          arbiter_busy;

    modport slave (
        input  request_in,
        output request_ready,
        input  fifo_setup_signal,
        input  downstream_prog_full,
        input  response_retire,
        output request_out,
        output credits_available,
        output arbiter_busy
    );

    modport master (
        output request_in,
        input  request_ready,
        output fifo_setup_signal,
        output downstream_prog_full,
        output response_retire,
        input  request_out,
        input  credits_available,
        input  arbiter_busy
    );

endinterface

// File: rtl/arbiter_n_to_1_request_cache_rr_encoder.sv
// Combinational round-robin priority encoder: first valid index at or after
// ptr (mod N) wins; returns a one-hot grant, its index and an any-valid flag.
module round_robin_priority_encoder
    import arbiter_n_to_1_request_cache_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    always_comb begin
        int unsigned      j;
        logic [IDX_W-1:0] jj;
        j     = 0;
        jj    = '0;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j  = rr_wrap(int'(ptr) + k, N);
            jj = IDX_W'(j);
            if (!any && valid[jj]) begin
                any       = 1'b1;
                grant[jj] = 1'b1;
                index     = jj;
            end
        end
    end

endmodule

// File: rtl/arbiter_n_to_1_request_cache.sv
// Round-robin N-to-1 arbiter in front of the cache request port, gated by
// setup, prog_full and (with ARBITER_REQUEST_CREDIT_EN) a response credit budget.
module arbiter_n_to_1_request_cache
    import arbiter_n_to_1_request_cache_pkg::*;
#(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int FIFO_ARBITER_DEPTH   = 16,
    parameter int CREDIT_W             = $clog2(FIFO_ARBITER_DEPTH + 1)
) (
    input logic                           ap_clk,
    input logic                           ap_rst_n,
    arbiter_n_to_1_request_cache_if.slave bus
);

    localparam int N     = NUM_MEMORY_REQUESTOR;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (N < 2 || N > ARBITER_MAX_REQUESTORS) begin : g_bad_n
            $error("NUM_MEMORY_REQUESTOR must be in 2..%0d", ARBITER_MAX_REQUESTORS);
        end
    endgenerate

    arbiter_request_state_t state, next_state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           grant_onehot;
    logic                   grant_any;
    logic                   grant_en;
    logic                   grant_fire;
    logic                   credit_ok;
    MemoryPacketRequest     out_q;

    for (genvar i = 0; i < N; i++) begin : g_valid
        assign req_valid[i] = bus.request_in[i].valid;
    end

    round_robin_priority_encoder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_enc (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant_onehot),
        .index (grant_idx),
        .any   (grant_any)
    );

    // prog_full and setup gate in the same cycle; prog_full slack covers the
    // one request already registered on request_out.
    assign grant_en          = (state == RUN) && !bus.fifo_setup_signal &&
                               !bus.downstream_prog_full && credit_ok;
    assign bus.request_ready = grant_en ? grant_onehot : '0;
    assign grant_fire        = grant_en && grant_any;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= SETUP;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SETUP:   if (!bus.fifo_setup_signal) next_state = RUN;
            RUN:     if (bus.downstream_prog_full || !credit_ok) next_state = STALL;
            STALL:   if (!bus.downstream_prog_full && credit_ok) next_state = RUN;
            default: next_state = SETUP;
        endcase
        if (bus.fifo_setup_signal) next_state = SETUP;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_q  <= '0;
            rr_ptr <= '0;
        end else begin
            out_q.valid <= grant_fire;
            if (grant_fire) begin
                out_q.payload <= bus.request_in[grant_idx].payload;
                rr_ptr        <= IDX_W'(rr_wrap(int'(grant_idx) + 1, N));
            end
        end
    end

    assign bus.request_out = out_q;

`ifdef ARBITER_REQUEST_CREDIT_EN
    logic [CREDIT_W-1:0] credits;
    logic                retire_overflow;

    // Retire in the current cycle already frees a slot for this cycle's grant.
    assign credit_ok = (credits != '0) || bus.response_retire;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            credits         <= CREDIT_W'(FIFO_ARBITER_DEPTH);
            retire_overflow <= 1'b0;
        end else begin
            case ({grant_fire, bus.response_retire})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CREDIT_W'(FIFO_ARBITER_DEPTH)) retire_overflow <= 1'b1;
                    else                                          credits <= credits + 1'b1;
                end
                default: credits <= credits;
            endcase
        end
    end

    // Sticky: a retire with nothing outstanding means the response path lost sync.
    always_ff @(posedge ap_clk) begin
        if (ap_rst_n) assert (!retire_overflow);
    end

    assign bus.credits_available = credits;
    assign bus.arbiter_busy      = (credits != CREDIT_W'(FIFO_ARBITER_DEPTH)) || out_q.valid;
`else
    logic unused_retire;

    assign unused_retire         = bus.response_retire;
    assign credit_ok             = 1'b1;
    assign bus.credits_available = CREDIT_W'(FIFO_ARBITER_DEPTH);
    assign bus.arbiter_busy      = out_q.valid;
`endif

endmodule

// File: tb/tb_arbiter_n_to_1_request_cache.sv
// Directed bench for arbiter_n_to_1_request_cache; expected grants are pushed
// to a queue at drive time and popped when request_out is sampled.
module tb_arbiter_n_to_1_request_cache;
    import arbiter_n_to_1_request_cache_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    arbiter_n_to_1_request_cache_if #(.NUM_MEMORY_REQUESTOR(N), .CREDIT_W(CW)) bus ();

    arbiter_n_to_1_request_cache #(
        .NUM_MEMORY_REQUESTOR (N),
        .FIFO_ARBITER_DEPTH   (DEPTH),
        .CREDIT_W             (CW)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    int                 checks = 0;
    int                 errors = 0;
    logic [N-1:0]       vld;
    int                 seq [N];
    logic               ret, setup, pfull;
    int                 exp_credits;
    logic               last_valid;
    MemoryPacketPayload last_payload;
    MemoryPacketRequest exp_q [$];

    function automatic MemoryPacketPayload mk(input int i, input int s);
        MemoryPacketPayload p;
        p.addr = 32'((i + 1) << 28) | 32'(s << 2);
        p.meta = 16'(s) ^ 16'(i << 12) ^ 16'hA5A5;
        return p;
    endfunction

    function automatic logic exp_busy();
`ifdef ARBITER_REQUEST_CREDIT_EN
        return (exp_credits != DEPTH) || last_valid;
`else
        return last_valid;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.request_in[i].valid   = vld[i];
            bus.request_in[i].payload = mk(i, seq[i]);
        end
        bus.response_retire      = ret;
        bus.fifo_setup_signal    = setup;
        bus.downstream_prog_full = pfull;
    endtask

    // One clock: check combinational ready and registered status, then the
    // registered output one cycle after the expected grant.
    task automatic cyc(input logic [N-1:0] exp_rdy, input string tag);
        MemoryPacketRequest e, o;
        int   w;
        logic g;
        drive();
        #2;
        chk({tag, " ready"}, 64'(bus.request_ready), 64'(exp_rdy));
        chk({tag, " credits"}, 64'(bus.credits_available), 64'(exp_credits));
        chk({tag, " busy"}, 64'(bus.arbiter_busy), 64'(exp_busy()));
        g = |exp_rdy;
        w = 0;
        for (int i = 0; i < N; i++) if (exp_rdy[i]) w = i;
        e.valid   = g;
        e.payload = g ? mk(w, seq[w]) : last_payload;
        exp_q.push_back(e);
`ifdef ARBITER_REQUEST_CREDIT_EN
        if (g && !ret)                           exp_credits--;
        else if (!g && ret && exp_credits < DEPTH) exp_credits++;
`endif
        if (g) seq[w]++;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = bus.request_out;
        chk({tag, " out.valid"}, 64'(o.valid), 64'(e.valid));
        chk({tag, " out.payload"}, 64'(o.payload), 64'(e.payload));
        last_valid   = e.valid;
        last_payload = e.payload;
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        vld          = 2'b11;
        ret          = 1'b0;
        setup        = 1'b1;
        pfull        = 1'b0;
        exp_credits  = DEPTH;
        last_valid   = 1'b0;
        last_payload = '0;
        drive();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out.valid", 64'(bus.request_out.valid), 64'(0));
        chk("reset out.payload", 64'(bus.request_out.payload), 64'(0));
        chk("reset ready", 64'(bus.request_ready), 64'(0));
        chk("reset credits", 64'(bus.credits_available), 64'(DEPTH));
        chk("reset busy", 64'(bus.arbiter_busy), 64'(0));
        rst_n = 1'b1;

        // Setup held high: no grants even with both requesters valid
        for (int k = 0; k < 5; k++) cyc(2'b00, "setup");
        setup = 1'b0;
        cyc(2'b00, "setup_exit");
        cyc(2'b01, "first_grant");

        for (int k = 0; k < 8; k++) cyc((k % 2 == 0) ? 2'b10 : 2'b01, "alternate");

        vld = 2'b10;
        for (int k = 0; k < 3; k++) cyc(2'b10, "only_req1");
        vld = 2'b11;
        cyc(2'b01, "ptr_wrap");

        vld = 2'b00;
        ret = 1'b1;
        for (int k = 0; k < 13; k++) cyc(2'b00, "retire_idle");
        ret = 1'b0;

        vld = 2'b11;
        cyc(2'b10, "pre_pfull");
        pfull = 1'b1;
        for (int k = 0; k < 4; k++) cyc(2'b00, "pfull");
        pfull = 1'b0;
        cyc(2'b00, "pfull_release");
        cyc(2'b01, "resume0");
        cyc(2'b10, "resume1");

        for (int k = 0; k < 8; k++) cyc((k % 2 == 0) ? 2'b01 : 2'b10, "drain_to5");
        ret = 1'b1;
        cyc(2'b01, "grant_and_retire");
        ret = 1'b0;
        cyc(2'b10, "burst");
        cyc(2'b01, "pre_reset");

        // Asynchronous reset mid-burst
        rst_n = 1'b0;
        #1;
        chk("midrst out.valid", 64'(bus.request_out.valid), 64'(0));
        chk("midrst out.payload", 64'(bus.request_out.payload), 64'(0));
        chk("midrst credits", 64'(bus.credits_available), 64'(DEPTH));
        chk("midrst ready", 64'(bus.request_ready), 64'(0));
        chk("midrst busy", 64'(bus.arbiter_busy), 64'(0));
        exp_credits  = DEPTH;
        last_valid   = 1'b0;
        last_payload = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2'b00, "post_reset");

        for (int k = 0; k < 16; k++) cyc((k % 2 == 0) ? 2'b01 : 2'b10, "sixteen");
`ifdef ARBITER_REQUEST_CREDIT_EN
        cyc(2'b00, "cred_zero");
        cyc(2'b00, "stall");
        ret = 1'b1;
        cyc(2'b00, "stall_retire");
        ret = 1'b0;
        cyc(2'b01, "one_after_retire");
        cyc(2'b00, "cred_zero_again");
`else
        ret = 1'b1;
        cyc(2'b01, "no_credit_gate0");
        ret = 1'b0;
        cyc(2'b10, "no_credit_gate1");
`endif
        vld = 2'b00;
        cyc(2'b00, "idle0");
        cyc(2'b00, "idle1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter_n_to_1_request_cache.md
# arbiter_N_to_1_request_cache

Round-robin arbiter that shares the single cache request port among `NUM_MEMORY_REQUESTOR` requesters (the CU setup engine and the CU bundles), and issues one request per cycle at most. It sits in front of the cache, mirroring the 1-to-N response arbiter on the return path. It gates grants on downstream back-pressure, on response-path setup, and on an outstanding-response credit budget sized to the response FIFO. This keeps that FIFO from overflowing.

## Interface
Parameters:
- `NUM_MEMORY_REQUESTOR`, 2: number of requesters; legal range 2..8.
- `FIFO_ARBITER_DEPTH`, 16: response FIFO depth; equals the credit budget.
- `CREDIT_W`, `$clog2(FIFO_ARBITER_DEPTH+1)`: credit counter width.

Ports (`N` = `NUM_MEMORY_REQUESTOR`):
- `ap_clk` in 1: clock; all logic on rising edge.
- `ap_rst_n` in 1: reset, asynchronous assert, active-low.
- `request_in[N-1:0]` in `MemoryPacketRequest`: per-requester request, valid + payload.
- `request_ready[N-1:0]` out N: per-requester accept.
- `fifo_setup_signal` in 1: response path still resetting; no grants while high.
- `downstream_prog_full` in 1: cache request FIFO prog_full.
- `response_retire` in 1: one-cycle pulse per response popped from the response FIFO.
- `request_out` out `MemoryPacketRequest`: granted request, registered.
- `credits_available` out `CREDIT_W`: free response slots.
- `arbiter_busy` out 1: high when outstanding responses > 0 or `request_out.valid` = 1.

## Operation
- Handshake: a transfer on requester i occurs when `request_in[i].valid & request_ready[i]`. `request_ready` is one-hot or zero, and combinational from valids, pointer, state and credits. Requesters hold valid and payload until accepted.
- Arbitration: round-robin, starting from `rr_ptr`. The first valid index at or after `rr_ptr` (mod N) wins. After a grant to i, `rr_ptr` = (i+1) mod N. The pointer is unchanged when there is no grant.
- FSM states:
  - `SETUP` (reset state): ready = 0. Go to `RUN` when `fifo_setup_signal` is low.
  - `RUN`: grants allowed. Go to `STALL` when `downstream_prog_full`, or when credits = 0 with no retire this cycle.
  - `STALL`: ready = 0. Go to `RUN` when `~downstream_prog_full` and credits > 0.
  - Any state: go to `SETUP` when `fifo_setup_signal` rises.
- Credits: reset to `FIFO_ARBITER_DEPTH`. Decrement on grant, increment on `response_retire`. On a simultaneous grant and retire, the count is unchanged.
  - A retire at full count is ignored (saturates) and sets the sticky simulation assertion flag.
  - A grant is never issued at 0 credits.
- Output: `request_out.valid` is the registered grant. `request_out.payload` is the registered payload of the winner and holds its last value when not valid.

## Timing
- Reset values:
  - `request_out.valid` = 0, payload = 0.
  - `request_ready` = 0.
  - `credits_available` = `FIFO_ARBITER_DEPTH`.
  - `arbiter_busy` = 0, `rr_ptr` = 0, state = `SETUP`.
- Latency: an accepted `request_in` appears on `request_out` exactly 1 cycle later.
- Throughput: 1 grant per cycle in `RUN`.
- Back-pressure: `downstream_prog_full` is sampled the same cycle. The prog_full slack absorbs the 1-cycle in-flight request.
- `credits_available` reflects the registered count. The decision uses count + retire of the current cycle.
- Reset mid-operation: in-flight `request_out` is dropped and credits reload. The response path is reset in the same domain.

## Configuration
- `ARBITER_REQUEST_CREDIT_EN`:
  - Defined: credit counter, credit gating and the `credits_available` output are active.
  - Undefined: the counter is removed. `credits_available` is tied to `FIFO_ARBITER_DEPTH`, `response_retire` is ignored, and only `downstream_prog_full` and setup gate grants.

## Structure
- Shared package (`global_package`):
  - `MemoryPacketRequest` (already present).
  - New enum `arbiter_request_state_t` {`SETUP`, `RUN`, `STALL`}.
  - Constant `ARBITER_MAX_REQUESTORS` = 8.
- Sub-module: `round_robin_priority_encoder` (valid vector + pointer -> one-hot grant + index). Pure combinational, reusable by other arbiters.

## Test plan
- Reset, `fifo_setup_signal` high for 5 cycles, both valid -> no ready until setup low. First grant goes to requester 0 and `request_out.valid` follows 1 cycle later.
- N=2, both valid continuously for 8 cycles, credits ample -> grants alternate 0,1,0,1…, four each, 1/cycle.
- Only requester 1 valid for 3 cycles -> three back-to-back grants to 1, then `rr_ptr` = 0.
- 16 grants with no retire -> `credits_available` = 0, state `STALL`, ready = 0. One retire pulse -> next cycle one grant, credits back to 0.
- `downstream_prog_full` high 4 cycles mid-stream -> zero grants in that window, resume in the same round-robin order.
- Grant and retire in the same cycle at credits = 5 -> credits stay 5; `ap_rst_n` low mid-burst -> `request_out.valid` = 0 immediately, credits = 16.
